// File: rtl/bus_arbiter_4way16.sv
// Round-robin arbiter sharing one registered 16-bit output channel between four requesters.
// A grant lasts up to MAX_BURST accepted beats; the releasing owner then drops to lowest priority.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | no owner; arbitrate among req starting after ptr_q
//  S_OWN  | owner_q holds the channel; beats accepted while free
module bus_arbiter_4way16 #(
    parameter int         MAX_BURST = 4,
    parameter logic [1:0] INIT_PTR  = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic [15:0] data_c,
    input  logic [15:0] data_d,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic        busy,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int             CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t          state_q;
    logic [1:0]      owner_q;
    logic [1:0]      ptr_q;
    logic [CW-1:0]   beat_cnt_q;
    logic [3:0]      gnt_q;
    logic            busy_q;
    logic [15:0]     out_data_q;
    logic            out_valid_q;

    logic            free;
    logic            accept;
    logic [1:0]      pick_d;
    logic [1:0]      cand;
    logic            found;
    logic [15:0]     word_d;

    assign free   = !out_valid_q || out_ready;
    assign accept = (state_q == S_OWN) && req[owner_q] && free;

    // Scan ptr+1, ptr+2, ... so the last owner is considered last.
    always_comb begin
        pick_d = ptr_q + 2'd1;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k < 5; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                pick_d = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (owner_q)
            2'd0:    word_d = data_a;
            2'd1:    word_d = data_b;
            2'd2:    word_d = data_c;
            default: word_d = data_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd0;
            ptr_q       <= INIT_PTR;
            beat_cnt_q  <= '0;
            gnt_q       <= 4'b0000;
            busy_q      <= 1'b0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready && !accept) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q    <= S_OWN;
                        owner_q    <= pick_d;
                        gnt_q      <= 4'b0001 << pick_d;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                S_OWN: begin
                    if (accept) begin
                        out_data_q  <= word_d;
                        out_valid_q <= 1'b1;
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q    <= S_IDLE;
                            ptr_q      <= owner_q;
                            gnt_q      <= 4'b0000;
                            busy_q     <= 1'b0;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end else if (!req[owner_q]) begin
                        state_q <= S_IDLE;
                        ptr_q   <= owner_q;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = owner_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bus_arbiter_4way16.sv
// Scenario bench for bus_arbiter_4way16: producers tag each word with source and sequence,
// accepted words are queued and matched against the consumer side in order.
module tb_bus_arbiter_4way16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data_a, data_b, data_c, data_d;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int nvec = 0;
    int nerr = 0;

    logic [15:0] sb [$];
    logic [11:0] seq [4] = '{12'h000, 12'h100, 12'h200, 12'h300};
    logic [3:0]  acc;
    logic        use_beef = 1'b0;
    int          tagcnt [16] = '{default: 0};

    bus_arbiter_4way16 #(.MAX_BURST(4), .INIT_PTR(2'd3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
        .gnt(gnt), .sel(sel), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] gen(input int i, input logic [11:0] s);
        return {4'hA + 4'(i), s};
    endfunction

    assign data_a = gen(0, seq[0]);
    assign data_b = gen(1, seq[1]);
    assign data_c = use_beef ? 16'hBEEF : gen(2, seq[2]);
    assign data_d = gen(3, seq[3]);

    // Consumer check first, then record words the producers hand over this cycle.
    always @(negedge clk) begin
        logic [15:0] w;
        acc = 4'b0000;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                nvec++;
                tagcnt[out_data[15:12]]++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_unexpected got %h want none", out_data);
                end else begin
                    w = sb.pop_front();
                    if (out_data !== w) begin
                        nerr++;
                        $display("FAIL sb_word got %h want %h", out_data, w);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (gnt[i] && req[i] && (!out_valid || out_ready)) begin
                    acc[i] = 1'b1;
                    case (i)
                        0:       sb.push_back(data_a);
                        1:       sb.push_back(data_b);
                        2:       sb.push_back(data_c);
                        default: sb.push_back(data_d);
                    endcase
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) seq[i] <= seq[i] + 12'd1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        req = 4'b0000;
        out_ready = 1'b1;
        repeat (6) cyc();
        smp();
        nvec++;
        if (sb.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL %s_drain got pending=%0d busy=%b valid=%b want 0 0 0",
                     name, sb.size(), busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        smp();
        nvec++;
        if (gnt !== 4'b0000) begin nerr++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", out_valid); end
        nvec++;
        if (out_data !== 16'h0000) begin nerr++; $display("FAIL reset_data got %h want 0000", out_data); end
        nvec++;
        if (busy !== 1'b0 || sel !== 2'd0) begin
            nerr++; $display("FAIL reset_busy_sel got %b %0d want 0 0", busy, sel);
        end
        cyc();
        rst_n = 1'b1; req = 4'b0000;
        smp();
    endtask

    task automatic test_single();
        cyc();
        use_beef = 1'b1; req = 4'b0100;
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || sel !== 2'd2) begin
            nerr++; $display("FAIL single_grant got gnt=%b busy=%b sel=%0d want 0100 1 2", gnt, busy, sel);
        end
        nvec++;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        cyc();
        req = 4'b0000;
        smp();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
            nerr++; $display("FAIL single_word got %b %h want 1 beef", out_valid, out_data);
        end
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL single_release got gnt=%b busy=%b valid=%b want 0000 0 0", gnt, busy, out_valid);
        end
        use_beef = 1'b0;
        cyc();
        req = 4'b1011;
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b1000) begin nerr++; $display("FAIL single_ptr2_next got %b want 1000", gnt); end
        cyc();
        req = 4'b0000;
        drain("single");
    endtask

    task automatic test_rotation();
        logic [3:0] e;
        cyc();
        req = 4'hF;
        for (int k = 0; k < 25; k++) begin
            cyc(); smp();
            e = ((k % 5) < 4) ? (4'b0001 << ((k / 5) % 4)) : 4'b0000;
            nvec++;
            if (gnt !== e) begin
                nerr++; $display("FAIL rotation_gnt cyc=%0d got %b want %b", k, gnt, e);
            end
        end
        drain("rotation");
    endtask

    task automatic test_early_release();
        int a0, d0;
        a0 = tagcnt[4'hA];
        d0 = tagcnt[4'hD];
        cyc();
        req = 4'b0001;
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b0001) begin nerr++; $display("FAIL early_grant0 got %b want 0001", gnt); end
        cyc();
        req = 4'b1001;
        smp();
        cyc();
        req = 4'b1000;
        smp();
        nvec++;
        if (gnt !== 4'b0001) begin nerr++; $display("FAIL early_nonowner_ignored got %b want 0001", gnt); end
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b0000) begin nerr++; $display("FAIL early_bubble got %b want 0000", gnt); end
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b1000) begin nerr++; $display("FAIL early_grant3 got %b want 1000", gnt); end
        drain("early");
        nvec++;
        if (tagcnt[4'hA] - a0 != 2 || tagcnt[4'hD] != d0) begin
            nerr++; $display("FAIL early_word_count got a=%0d d=%0d want 2 0", tagcnt[4'hA] - a0, tagcnt[4'hD] - d0);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] s0;
        cyc();
        req = 4'b0010;
        s0 = seq[1];
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b0010) begin nerr++; $display("FAIL bp_grant got %b want 0010", gnt); end
        cyc();
        out_ready = 1'b0;
        smp();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== gen(1, s0)) begin
            nerr++; $display("FAIL bp_first got %b %h want 1 %h", out_valid, out_data, gen(1, s0));
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) out_ready = 1'b1;
            smp();
            nvec++;
            if (out_data !== gen(1, s0) || gnt !== 4'b0010 || out_valid !== 1'b1) begin
                nerr++; $display("FAIL bp_stall cyc=%0d got %h gnt=%b want %h 0010", i, out_data, gnt, gen(1, s0));
            end
        end
        for (int b = 1; b < 4; b++) begin
            cyc(); smp();
            nvec++;
            if (out_data !== gen(1, s0 + 12'(b))) begin
                nerr++; $display("FAIL bp_resume beat=%0d got %h want %h", b, out_data, gen(1, s0 + 12'(b)));
            end
            nvec++;
            if (gnt !== ((b < 3) ? 4'b0010 : 4'b0000)) begin
                nerr++; $display("FAIL bp_burst_len beat=%0d got %b want %b", b, gnt, (b < 3) ? 4'b0010 : 4'b0000);
            end
        end
        drain("bp");
    endtask

    task automatic test_midburst_reset();
        cyc();
        req = 4'b0100;
        cyc(); smp();
        cyc();
        out_ready = 1'b0; req = 4'hF;
        smp();
        nvec++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || gnt !== 4'b0100) begin
            nerr++; $display("FAIL mrst_pre got valid=%b busy=%b gnt=%b want 1 1 0100", out_valid, busy, gnt);
        end
        cyc();
        rst_n = 1'b0;
        smp();
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        smp();
        nvec++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
            nerr++; $display("FAIL mrst_state got gnt=%b busy=%b sel=%0d want 0000 0 0", gnt, busy, sel);
        end
        nvec++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            nerr++; $display("FAIL mrst_output got %b %h want 0 0000", out_valid, out_data);
        end
        cyc(); smp();
        nvec++;
        if (gnt !== 4'b0001) begin nerr++; $display("FAIL mrst_ptr_init got %b want 0001", gnt); end
        drain("mrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_backpressure();
        test_midburst_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
